simd_pe_sequencer: RTL and testbench

Instruction sequencer for the Processing_Element datapath in the SIMD core. Accepts one decoded instruction at a time over a valid/ready handshake, latches its fields and steps the PE through decode, execute or multiply, and writeback. It owns the PE control lines (op select, enable, RST_MUL, multiply enable) and the register-file read/write addresses for all lanes, which share one control word.

---
 rtl/simd_pe_sequencer_if.sv | 41 ++++
 rtl/simd_pe_sequencer.sv | 164 ++++++++++++++++
 tb/tb_simd_pe_sequencer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/simd_pe_sequencer_if.sv
// Instruction handshake and PE/register-file control bundle for the SIMD PE sequencer.
// The master modport issues instructions; the slave modport is the sequencer.
interface simd_pe_sequencer_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned RA = 3
);
  logic          INSTR_VALID;
  logic          INSTR_READY;
  logic [3:0]    INSTR_OP;
  logic [RA-1:0] INSTR_RD;
  logic [RA-1:0] INSTR_RS1;
  logic [RA-1:0] INSTR_RS2;
  logic [N-1:0]  INSTR_IMM;
  logic          FLUSH;

  logic [3:0]    PE_OP;
  logic          PE_EN;
  logic          RST_MUL;
  logic          MUL_EN;
  logic          IMM_SEL;
  logic [N-1:0]  IMM_OUT;
  logic [RA-1:0] RF_RADDR1;
  logic [RA-1:0] RF_RADDR2;
  logic [RA-1:0] RF_WADDR;
  logic          RF_WE;
  logic          DONE;
  logic          ILLEGAL;
  logic          BUSY;

  modport master (
    output INSTR_VALID, INSTR_OP, INSTR_RD, INSTR_RS1, INSTR_RS2, INSTR_IMM, FLUSH,
    input  INSTR_READY, PE_OP, PE_EN, RST_MUL, MUL_EN, IMM_SEL, IMM_OUT,
           RF_RADDR1, RF_RADDR2, RF_WADDR, RF_WE, DONE, ILLEGAL, BUSY
  );

  modport slave (
    input  INSTR_VALID, INSTR_OP, INSTR_RD, INSTR_RS1, INSTR_RS2, INSTR_IMM, FLUSH,
    output INSTR_READY, PE_OP, PE_EN, RST_MUL, MUL_EN, IMM_SEL, IMM_OUT,
           RF_RADDR1, RF_RADDR2, RF_WADDR, RF_WE, DONE, ILLEGAL, BUSY
  );
endinterface

// File: rtl/simd_pe_sequencer.sv
// Single-issue instruction sequencer driving the shared PE control word and register-file addresses.
// Every output is a register loaded from the next-state decode, so strobes line up with the state they belong to.
module simd_pe_sequencer #(
  parameter int unsigned N          = 16,
  parameter int unsigned MUL_CYCLES = 16,
  parameter int unsigned RA         = 3
) (
  input logic                 CLK,
  input logic                 RSTN,
  simd_pe_sequencer_if.slave  bus
);

  localparam int unsigned CW = 8;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_EXEC     = 3'd2;
  localparam logic [2:0] S_MUL_INIT = 3'd3;
  localparam logic [2:0] S_MUL_RUN  = 3'd4;
  localparam logic [2:0] S_WB       = 3'd5;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MUL = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;

  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [RA-1:0] rd_q, rd_d;
  logic [RA-1:0] rs1_q, rs1_d;
  logic [RA-1:0] rs2_q, rs2_d;
  logic [N-1:0]  imm_q, imm_d;

  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic pe_en_q, pe_en_d;
  logic rst_mul_q, rst_mul_d;
  logic mul_en_q, mul_en_d;
  logic imm_sel_q, imm_sel_d;
  logic rf_we_q, rf_we_d;
  logic done_q, done_d;
  logic illegal_q, illegal_d;

  logic op_is_alu;
  logic op_is_illegal;

  // State register plus latched fields and registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      pe_en_q   <= 1'b0;
      rst_mul_q <= 1'b0;
      mul_en_q  <= 1'b0;
      imm_sel_q <= 1'b0;
      rf_we_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      pe_en_q   <= pe_en_d;
      rst_mul_q <= rst_mul_d;
      mul_en_q  <= mul_en_d;
      imm_sel_q <= imm_sel_d;
      rf_we_q   <= rf_we_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state, field capture, and output decode of the upcoming state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;

    case (state_q)
      S_IDLE: begin
        if (bus.INSTR_VALID) begin
          op_d    = bus.INSTR_OP;
          rd_d    = bus.INSTR_RD;
          rs1_d   = bus.INSTR_RS1;
          rs2_d   = bus.INSTR_RS2;
          imm_d   = bus.INSTR_IMM;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_q == OP_MUL)                        state_d = S_MUL_INIT;
        else if (op_q == OP_LDI)                   state_d = S_WB;
        else if (op_q >= OP_ADD && op_q <= OP_XOR) state_d = S_EXEC;
        else                                       state_d = S_IDLE;
      end
      S_EXEC:     state_d = S_WB;
      S_MUL_INIT: begin
        cnt_d   = '0;
        state_d = S_MUL_RUN;
      end
      S_MUL_RUN: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        if (cnt_q == MUL_LAST) state_d = S_WB;
      end
      S_WB:       state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Abort wins over every transition; an already-issued WB strobe is unaffected.
    if (bus.FLUSH && (state_q != S_IDLE)) state_d = S_IDLE;

    op_is_alu     = (op_d >= OP_ADD) && (op_d <= OP_XOR);
    op_is_illegal = op_d[3];

    ready_d   = (state_d == S_IDLE);
    busy_d    = (state_d != S_IDLE);
    pe_en_d   = (state_d == S_EXEC);
    rst_mul_d = (state_d == S_MUL_INIT);
    mul_en_d  = (state_d == S_MUL_RUN);
    rf_we_d   = (state_d == S_WB);
    imm_sel_d = (state_d == S_WB) && (op_d == OP_LDI);
    illegal_d = (state_d == S_DECODE) && op_is_illegal;
    done_d    = (state_d == S_WB) ||
                ((state_d == S_DECODE) && ((op_d == OP_NOP) || op_is_illegal));
  end

  assign bus.INSTR_READY = ready_q;
  assign bus.BUSY        = busy_q;
  assign bus.PE_OP       = op_q;
  assign bus.PE_EN       = pe_en_q;
  assign bus.RST_MUL     = rst_mul_q;
  assign bus.MUL_EN      = mul_en_q;
  assign bus.IMM_SEL     = imm_sel_q;
  assign bus.IMM_OUT     = imm_q;
  assign bus.RF_RADDR1   = rs1_q;
  assign bus.RF_RADDR2   = rs2_q;
  assign bus.RF_WADDR    = rd_q;
  assign bus.RF_WE       = rf_we_q;
  assign bus.DONE        = done_q;
  assign bus.ILLEGAL     = illegal_q;

endmodule

// File: tb/tb_simd_pe_sequencer.sv
// Directed bench for simd_pe_sequencer: a vector table of single instructions run back-to-back,
// plus hand sequences for flush, mid-multiply reset and handshake stall.
module tb_simd_pe_sequencer;

  localparam int unsigned N          = 16;
  localparam int unsigned RA         = 3;
  localparam int unsigned MUL_CYCLES = 16;
  localparam int          MAX_CYC    = 40;

  logic CLK  = 1'b0;
  logic RSTN = 1'b0;

  always #5 CLK = ~CLK;

  simd_pe_sequencer_if #(.N(N), .RA(RA)) bus ();

  simd_pe_sequencer #(.N(N), .MUL_CYCLES(MUL_CYCLES), .RA(RA)) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    int          done_cyc;
    int          we_cyc;
    int          pe_en_cyc;
    int          rst_cyc;
    int          mul_cnt;
    bit          illegal;
    bit          imm_sel;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2, input logic [15:0] imm);
    bus.INSTR_VALID = v;
    bus.INSTR_OP    = op;
    bus.INSTR_RD    = rd;
    bus.INSTR_RS1   = rs1;
    bus.INSTR_RS2   = rs2;
    bus.INSTR_IMM   = imm;
  endtask

  // Issue one instruction from IDLE and watch it until DONE, then confirm return to IDLE.
  task automatic run_vec(input vec_t v, input logic flush_at_accept);
    int c;
    int done_c, we_c, pe_c, rst_c, rst_n_seen, mul_n, mul_first;
    logic ill, sel;
    logic [2:0]  waddr;
    logic [15:0] immo;
    done_c = 0; we_c = 0; pe_c = 0; rst_c = 0; rst_n_seen = 0; mul_n = 0; mul_first = 0;
    ill = 1'b0; sel = 1'b0; waddr = '0; immo = '0;

    check({v.name, " ready"}, 32'(bus.INSTR_READY), 32'd1);
    drive(1'b1, v.op, v.rd, v.rs1, v.rs2, v.imm);
    bus.FLUSH = flush_at_accept;
    tick();
    drive(1'b0, 4'hF, 3'h7, 3'h7, 3'h7, 16'hFFFF);
    bus.FLUSH = 1'b0;
    check({v.name, " pe_op@1"}, 32'(bus.PE_OP), 32'(v.op));
    check({v.name, " raddr1@1"}, 32'(bus.RF_RADDR1), 32'(v.rs1));
    check({v.name, " raddr2@1"}, 32'(bus.RF_RADDR2), 32'(v.rs2));

    c = 1;
    while (1) begin
      if (bus.RF_WE)   begin we_c = c; waddr = bus.RF_WADDR; sel = bus.IMM_SEL; immo = bus.IMM_OUT; end
      if (bus.ILLEGAL) ill = 1'b1;
      if (bus.PE_EN)   pe_c = c;
      if (bus.RST_MUL) begin rst_c = c; rst_n_seen++; end
      if (bus.MUL_EN)  begin if (mul_n == 0) mul_first = c; mul_n++; end
      if (bus.DONE)    done_c = c;
      if (bus.DONE || c >= MAX_CYC) break;
      tick();
      c++;
    end

    check({v.name, " done_cyc"}, 32'(done_c), 32'(v.done_cyc));
    check({v.name, " we_cyc"}, 32'(we_c), 32'(v.we_cyc));
    check({v.name, " illegal"}, 32'(ill), 32'(v.illegal));
    check({v.name, " pe_en_cyc"}, 32'(pe_c), 32'(v.pe_en_cyc));
    check({v.name, " rst_mul_cyc"}, 32'(rst_c), 32'(v.rst_cyc));
    check({v.name, " rst_mul_cnt"}, 32'(rst_n_seen), (v.rst_cyc != 0) ? 32'd1 : 32'd0);
    check({v.name, " mul_en_cnt"}, 32'(mul_n), 32'(v.mul_cnt));
    check({v.name, " mul_en_first"}, 32'(mul_first), (v.mul_cnt != 0) ? 32'd3 : 32'd0);
    check({v.name, " imm_sel"}, 32'(sel), 32'(v.imm_sel));
    if (v.we_cyc != 0) check({v.name, " waddr"}, 32'(waddr), 32'(v.rd));
    if (v.imm_sel)     check({v.name, " imm_out"}, 32'(immo), 32'(v.imm));

    tick();
    check({v.name, " ready_after"}, 32'(bus.INSTR_READY), 32'd1);
    check({v.name, " busy_after"}, 32'(bus.BUSY), 32'd0);
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.PE_EN, bus.RST_MUL, bus.MUL_EN, bus.IMM_SEL, bus.RF_WE, bus.DONE, bus.ILLEGAL, bus.BUSY});
  endfunction

  initial begin
    int seen;
    //            name   op     rd    rs1   rs2   imm       done we  pe rst mul ill sel
    vecs[0]  = '{"ADD",  4'd1,  3'd3, 3'd1, 3'd2, 16'h0000,  3,  3,  2, 0,  0, 0, 0};
    vecs[1]  = '{"SUB",  4'd2,  3'd6, 3'd7, 3'd0, 16'h1234,  3,  3,  2, 0,  0, 0, 0};
    vecs[2]  = '{"AND",  4'd3,  3'd0, 3'd5, 3'd4, 16'h0000,  3,  3,  2, 0,  0, 0, 0};
    vecs[3]  = '{"XOR",  4'd5,  3'd7, 3'd3, 3'd3, 16'h0000,  3,  3,  2, 0,  0, 0, 0};
    vecs[4]  = '{"OR",   4'd4,  3'd1, 3'd6, 3'd2, 16'h0000,  3,  3,  2, 0,  0, 0, 0};
    vecs[5]  = '{"MUL",  4'd6,  3'd2, 3'd4, 3'd5, 16'h0000, 19, 19,  0, 2, 16, 0, 0};
    vecs[6]  = '{"LDI",  4'd7,  3'd5, 3'd0, 3'd0, 16'hBEEF,  2,  2,  0, 0,  0, 0, 1};
    vecs[7]  = '{"ILL12",4'd12, 3'd4, 3'd1, 3'd1, 16'h0000,  1,  0,  0, 0,  0, 1, 0};
    vecs[8]  = '{"NOP",  4'd0,  3'd6, 3'd2, 3'd3, 16'h0000,  1,  0,  0, 0,  0, 0, 0};
    vecs[9]  = '{"ILL15",4'd15, 3'd7, 3'd7, 3'd7, 16'h0000,  1,  0,  0, 0,  0, 1, 0};
    vecs[10] = '{"LDI1", 4'd7,  3'd0, 3'd1, 3'd2, 16'h0001,  2,  2,  0, 0,  0, 0, 1};

    drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    bus.FLUSH = 1'b0;

    // Reset held two cycles, then released.
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RSTN = 1'b1;
    tick();
    check("rst ready", 32'(bus.INSTR_READY), 32'd1);
    check("rst strobes", strobes(), 32'd0);
    check("rst pe_op", 32'(bus.PE_OP), 32'd0);
    check("rst imm_out", 32'(bus.IMM_OUT), 32'd0);
    check("rst waddr", 32'(bus.RF_WADDR), 32'd0);

    // Table, issued back-to-back.
    for (int i = 0; i < 11; i++) run_vec(vecs[i], 1'b0);

    // FLUSH in cycle 10 of a multiply.
    drive(1'b1, 4'd6, 3'd4, 3'd1, 3'd2, 16'h0000);
    tick();
    drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    for (int c = 2; c <= 10; c++) tick();
    check("flush mul_en@10", 32'(bus.MUL_EN), 32'd1);
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    check("flush busy", 32'(bus.BUSY), 32'd0);
    check("flush ready", 32'(bus.INSTR_READY), 32'd1);
    check("flush mul_en", 32'(bus.MUL_EN), 32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (bus.RF_WE || bus.DONE) seen++;
      tick();
    end
    check("flush no_we_done", 32'(seen), 32'd0);
    run_vec(vecs[0], 1'b1);

    // Asynchronous reset in cycle 10 of a multiply.
    drive(1'b1, 4'd6, 3'd5, 3'd3, 3'd4, 16'hA5A5);
    tick();
    drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    for (int c = 2; c <= 10; c++) tick();
    RSTN = 1'b0;
    #1;
    check("arst strobes", strobes(), 32'd0);
    check("arst pe_op", 32'(bus.PE_OP), 32'd0);
    check("arst imm_out", 32'(bus.IMM_OUT), 32'd0);
    check("arst waddr", 32'(bus.RF_WADDR), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    tick();
    check("arst ready", 32'(bus.INSTR_READY), 32'd1);
    run_vec(vecs[5], 1'b0);

    // Handshake stall: VALID held with changing fields during a multiply.
    drive(1'b1, 4'd6, 3'd2, 3'd1, 3'd3, 16'h0000);
    tick();
    for (int c = 1; c <= 18; c++) begin
      drive(1'b1, 4'd7, 3'(c), 3'(c + 1), 3'(c + 2), 16'(c));
      if (c == 10) begin
        check("stall pe_op@10", 32'(bus.PE_OP), 32'd6);
        check("stall ready@10", 32'(bus.INSTR_READY), 32'd0);
      end
      tick();
    end
    check("stall we@19", 32'(bus.RF_WE), 32'd1);
    check("stall waddr@19", 32'(bus.RF_WADDR), 32'd2);
    check("stall ready@19", 32'(bus.INSTR_READY), 32'd0);
    drive(1'b1, 4'd1, 3'd7, 3'd4, 3'd6, 16'h0000);
    tick();
    check("stall ready@20", 32'(bus.INSTR_READY), 32'd1);
    check("stall we@20", 32'(bus.RF_WE), 32'd0);
    tick();
    drive(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'h0000);
    check("stall2 pe_op", 32'(bus.PE_OP), 32'd1);
    check("stall2 raddr1", 32'(bus.RF_RADDR1), 32'd4);
    check("stall2 raddr2", 32'(bus.RF_RADDR2), 32'd6);
    tick();
    check("stall2 pe_en", 32'(bus.PE_EN), 32'd1);
    tick();
    check("stall2 we", 32'(bus.RF_WE), 32'd1);
    check("stall2 done", 32'(bus.DONE), 32'd1);
    check("stall2 waddr", 32'(bus.RF_WADDR), 32'd7);
    tick();
    check("stall2 ready", 32'(bus.INSTR_READY), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
